// File: rtl/mem_sram_bridge_pkg.sv
// Shared types and constants for the core-bus to asynchronous SRAM bridge.
package mem_sram_bridge_pkg;

  localparam int unsigned ADDR_W  = 19;  // word address [19:1]
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SRAM_AW = 20;  // byte address
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;

  // Legal range of the WAIT_STATES parameter (phase length N = WAIT_STATES+1).
  localparam int unsigned WS_MIN = 1;
  localparam int unsigned WS_MAX = 15;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_t;

  // Byte address of one lane of a word address.
  function automatic logic [SRAM_AW-1:0] byte_addr(input logic [ADDR_W-1:0] a,
                                                   input logic lane);
    return {a, lane};
  endfunction

endpackage

// File: rtl/mem_sram_bridge_if.sv
// Core memory bus (q_m_*) between the arbiter (master) and a responder (slave).
interface mem_sram_bridge_if;
  import mem_sram_bridge_pkg::*;

  logic [ADDR_W-1:0] q_m_addr;
  logic [DATA_W-1:0] q_m_data_in;
  logic [DATA_W-1:0] q_m_data_out;
  logic              q_m_access;
  logic              q_m_ack;
  logic              q_m_wr_en;
  logic [1:0]        q_m_bytesel;

  modport master (
    output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    input  q_m_data_in, q_m_ack
  );

  modport slave (
    input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
    output q_m_data_in, q_m_ack
  );
endinterface

// File: rtl/mem_sram_bridge.sv
// Completes one core-bus access as up to two timed 8-bit asynchronous SRAM cycles.
module mem_sram_bridge
  import mem_sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_sram_bridge_if.slave    q_m,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [BYTE_W-1:0]   sram_dq_out,
  input  logic [BYTE_W-1:0]   sram_dq_in,
  output logic                sram_dq_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  state_t              r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic                r_wr, w_wr;
  logic [1:0]          r_bs, w_bs;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic                r_ack;
  logic [DATA_W-1:0]   r_data_in;

  logic                w_in_phase;
  logic                w_lane;
  logic [SRAM_AW-1:0]  w_nxt_sram_addr;
  logic [BYTE_W-1:0]   w_nxt_dq_out;
  logic                w_nxt_dq_oe, w_nxt_ce_n, w_nxt_oe_n, w_nxt_we_n;
  logic                w_nxt_ack;
  logic [DATA_W-1:0]   w_nxt_data_in;

  assign q_m.q_m_ack     = r_ack;
  assign q_m.q_m_data_in = r_data_in;

  // Request fields come straight from the bus while idle, from the latched copy afterwards.
  assign w_addr  = (r_state == IDLE) ? q_m.q_m_addr     : r_addr;
  assign w_wdata = (r_state == IDLE) ? q_m.q_m_data_out : r_wdata;
  assign w_wr    = (r_state == IDLE) ? q_m.q_m_wr_en    : r_wr;
  assign w_bs    = (r_state == IDLE) ? q_m.q_m_bytesel  : r_bs;

  // State register, latched request, and registered pin/bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_bs        <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_data_in   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wr        <= w_wr;
      r_bs        <= w_bs;
      r_rdata     <= w_rdata;
      r_ack       <= w_nxt_ack;
      r_data_in   <= w_nxt_data_in;
      sram_addr   <= w_nxt_sram_addr;
      sram_dq_out <= w_nxt_dq_out;
      sram_dq_oe  <= w_nxt_dq_oe;
      sram_ce_n   <= w_nxt_ce_n;
      sram_oe_n   <= w_nxt_oe_n;
      sram_we_n   <= w_nxt_we_n;
    end
  end

  // Next state, phase counter, read capture, and next values of every output.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_rdata     = r_rdata;

    case (r_state)
      IDLE: begin
        if (q_m.q_m_access) begin
          w_rdata = '0;
          if (w_bs[0])      w_nxt_state = LO;
          else if (w_bs[1]) w_nxt_state = HI;
          else              w_nxt_state = ACK;
        end
      end
      LO: begin
        if (r_cnt == '0) begin
          if (!w_wr) w_rdata[BYTE_W-1:0] = sram_dq_in;
          w_nxt_state = w_bs[1] ? HI : ACK;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      HI: begin
        if (r_cnt == '0) begin
          if (!w_wr) w_rdata[DATA_W-1:BYTE_W] = sram_dq_in;
          w_nxt_state = ACK;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      ACK:     w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase

    w_in_phase = (w_nxt_state == LO) || (w_nxt_state == HI);
    w_lane     = (w_nxt_state == HI) ? LANE_HI : LANE_LO;

    // Fresh phase entry (from IDLE or LO->HI) reloads the counter.
    if (w_in_phase && (w_nxt_state != r_state)) w_nxt_cnt = CNT_W'(WAIT_STATES);

    w_nxt_sram_addr = w_in_phase ? byte_addr(w_addr, w_lane) : sram_addr;
    w_nxt_ce_n      = !w_in_phase;
    w_nxt_oe_n      = !(w_in_phase && !w_wr);
    w_nxt_dq_oe     = w_in_phase && w_wr;
    // Strobe low except on the last cycle of the phase, which holds data.
    w_nxt_we_n      = !(w_in_phase && w_wr && (w_nxt_cnt != '0));
    w_nxt_dq_out    = '0;
    if (w_in_phase && w_wr)
      w_nxt_dq_out = (w_lane == LANE_HI) ? w_wdata[DATA_W-1:BYTE_W] : w_wdata[BYTE_W-1:0];

    w_nxt_ack     = (w_nxt_state == ACK);
    w_nxt_data_in = ((w_nxt_state == ACK) && !w_wr) ? w_rdata : r_data_in;
  end

endmodule
